// File: rtl/lsq_param.sv
// lsq_param: parametrised load/store queue with in-order memory issue, commit-gated stores
// and optional store-to-load forwarding (compile with `define LSQ_FORWARD_EN to enable).
`timescale 1ns/1ps
module lsq_param #(
   parameter int DEPTH  = 16,
   parameter int ROB_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_rollback,
   input  logic              in_enq,
   input  logic [ROB_W-1:0]  in_enq_tag,
   input  logic              in_enq_store,
   input  logic [2:0]        in_enq_funct3,
   input  logic [ROB_W-1:0]  in_agu_tag,
   input  logic [DATA_W-1:0] in_agu_addr,
   input  logic [DATA_W-1:0] in_agu_data,
   input  logic [ROB_W-1:0]  in_commit_tag,
   output logic              out_full,
   output logic [DATA_W-1:0] out_result,
   output logic [ROB_W-1:0]  out_rob_tag,
   output logic              out_mem_ena,
   output logic              out_mem_iswrite,
   output logic [DATA_W-1:0] out_mem_addr,
   output logic [DATA_W-1:0] out_mem_wdata,
   output logic [2:0]        out_mem_size,
   input  logic              in_mem_ready,
   input  logic [DATA_W-1:0] in_mem_rdata
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT_ST, WAIT_LD} state_t;

   function automatic logic [2:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] extend(input logic [2:0] f3, input logic [DATA_W-1:0] d);
      case (f3)
         3'b000:  return {{(DATA_W-8){d[7]}}, d[7:0]};
         3'b001:  return {{(DATA_W-16){d[15]}}, d[15:0]};
         3'b100:  return {{(DATA_W-8){1'b0}}, d[7:0]};
         3'b101:  return {{(DATA_W-16){1'b0}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   logic [ROB_W-1:0]  e_tag  [DEPTH];
   logic [2:0]        e_f3   [DEPTH];
   logic [DATA_W-1:0] e_addr [DEPTH];
   logic [DATA_W-1:0] e_data [DEPTH];
   logic [DEPTH-1:0]  e_store, e_vld, e_cmt, e_done;

   logic [AW-1:0]     head, tail;
   logic [AW:0]       count;
   state_t            state;
   logic [ROB_W-1:0]  lat_tag;
   logic [2:0]        lat_f3;

   logic              enq_ok, mem_res, h_agu, h_cmt, head_vld, head_commit;
   logic              deq_done, do_issue, deq;
   logic [DATA_W-1:0] head_addr, head_data;
   logic              rb_found;
   logic [AW:0]       rb_len;
   logic              fwd_hit;
   logic [AW-1:0]     fwd_idx;
   logic [DATA_W-1:0] fwd_data;

   assign out_full = (count == (AW+1)'(DEPTH));
   assign enq_ok   = in_enq && !out_full && !in_rollback;
   assign mem_res  = (state == WAIT_LD) && in_mem_ready;

   // Head issue decision sees same-cycle AGU/commit broadcasts so the request leaves next edge.
   always_comb begin
      h_agu       = (in_agu_tag != '0) && (in_agu_tag == e_tag[head]);
      h_cmt       = (in_commit_tag != '0) && (in_commit_tag == e_tag[head]);
      head_vld    = e_vld[head] | h_agu;
      head_commit = e_cmt[head] | h_cmt;
      head_addr   = h_agu ? in_agu_addr : e_addr[head];
      head_data   = h_agu ? in_agu_data : e_data[head];
      deq_done    = !in_rollback && (state == IDLE) && (count != '0) && e_done[head];
      do_issue    = !in_rollback && (state == IDLE) && (count != '0) && !e_done[head] &&
                    head_vld && (!e_store[head] || head_commit);
      deq         = deq_done | do_issue;
   end

   // Rollback keeps everything up to and including the youngest committed store.
   always_comb begin
      rb_found = 1'b0;
      rb_len   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (((AW+1)'(k) < count) && e_store[head + AW'(k)] && e_cmt[head + AW'(k)]) begin
            rb_found = 1'b1;
            rb_len   = (AW+1)'(k + 1);
         end
      end
   end

`ifdef LSQ_FORWARD_EN
   logic          older_st;
   logic [AW-1:0] cur, prv;
   // Only the first load behind a run of valid stores can qualify, so the oldest wins naturally.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_idx  = '0;
      fwd_data = '0;
      older_st = 1'b1;
      cur      = '0;
      prv      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((AW+1)'(k) < count) begin
            cur = head + AW'(k);
            prv = cur - AW'(1);
            if (k > 0 && older_st && !fwd_hit && !e_store[cur] && e_vld[cur] && !e_done[cur] &&
                (e_addr[prv] == e_addr[cur]) && (size_of(e_f3[prv]) >= size_of(e_f3[cur]))) begin
               fwd_hit  = 1'b1;
               fwd_idx  = cur;
               fwd_data = extend(e_f3[cur], e_data[prv]);
            end
            older_st = older_st & e_store[cur] & e_vld[cur];
         end
      end
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_idx  = '0;
   assign fwd_data = '0;
`endif

   always_ff @(posedge clk) begin
      if (!in_rollback) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((in_agu_tag != '0) && (in_agu_tag == e_tag[i])) begin
               e_addr[i] <= in_agu_addr;
               e_data[i] <= in_agu_data;
            end
         end
         if (enq_ok) begin
            e_tag[tail]   <= in_enq_tag;
            e_store[tail] <= in_enq_store;
            e_f3[tail]    <= in_enq_funct3;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         state           <= IDLE;
         e_vld           <= '0;
         e_cmt           <= '0;
         e_done          <= '0;
         lat_tag         <= '0;
         lat_f3          <= '0;
         out_mem_ena     <= 1'b0;
         out_mem_iswrite <= 1'b0;
         out_mem_addr    <= '0;
         out_mem_wdata   <= '0;
         out_mem_size    <= '0;
         out_rob_tag     <= '0;
         out_result      <= '0;
      end else begin
         out_mem_ena <= 1'b0;
         out_rob_tag <= '0;
         out_result  <= '0;
         if (in_rollback) begin
            if (rb_found) begin
               tail  <= head + rb_len[AW-1:0];
               count <= rb_len;
            end else begin
               head  <= '0;
               tail  <= '0;
               count <= '0;
            end
            if (state == WAIT_LD || (state == WAIT_ST && in_mem_ready)) state <= IDLE;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if ((in_agu_tag != '0) && (in_agu_tag == e_tag[i]))       e_vld[i] <= 1'b1;
               if ((in_commit_tag != '0) && (in_commit_tag == e_tag[i])) e_cmt[i] <= 1'b1;
            end
            if (enq_ok) begin
               e_vld[tail]  <= 1'b0;
               e_cmt[tail]  <= 1'b0;
               e_done[tail] <= 1'b0;
               tail         <= tail + AW'(1);
            end
            if (fwd_hit && !mem_res) begin
               e_done[fwd_idx] <= 1'b1;
               out_rob_tag     <= e_tag[fwd_idx];
               out_result      <= fwd_data;
            end
            case (state)
               IDLE: if (do_issue) begin
                  out_mem_ena     <= 1'b1;
                  out_mem_iswrite <= e_store[head];
                  out_mem_addr    <= head_addr;
                  out_mem_wdata   <= head_data;
                  out_mem_size    <= size_of(e_f3[head]);
                  lat_tag         <= e_tag[head];
                  lat_f3          <= e_f3[head];
                  state           <= e_store[head] ? WAIT_ST : WAIT_LD;
               end
               WAIT_ST: if (in_mem_ready) state <= IDLE;
               WAIT_LD: if (in_mem_ready) begin
                  state       <= IDLE;
                  out_rob_tag <= lat_tag;
                  out_result  <= extend(lat_f3, in_mem_rdata);
               end
               default: state <= IDLE;
            endcase
            if (deq) head <= head + AW'(1);
            count <= count + (AW+1)'(enq_ok) - (AW+1)'(deq);
         end
      end
   end
endmodule

// File: tb/tb_lsq_param.sv
// Directed bench for lsq_param (DEPTH=4): issue/extension, commit gating, full/wrap,
// rollback during a pending load, async reset, and forwarding when LSQ_FORWARD_EN is set.
`timescale 1ns/1ps
module tb_lsq_param;
   localparam int DEPTH = 4, ROB_W = 4, DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_rollback, in_enq, in_enq_store, in_mem_ready;
   logic [ROB_W-1:0]  in_enq_tag, in_agu_tag, in_commit_tag;
   logic [2:0]        in_enq_funct3;
   logic [DATA_W-1:0] in_agu_addr, in_agu_data, in_mem_rdata;
   logic              out_full, out_mem_ena, out_mem_iswrite;
   logic [DATA_W-1:0] out_result, out_mem_addr, out_mem_wdata;
   logic [ROB_W-1:0]  out_rob_tag;
   logic [2:0]        out_mem_size;

   int checks = 0;
   int errors = 0;

   lsq_param #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_rollback(in_rollback),
      .in_enq(in_enq), .in_enq_tag(in_enq_tag), .in_enq_store(in_enq_store),
      .in_enq_funct3(in_enq_funct3), .in_agu_tag(in_agu_tag), .in_agu_addr(in_agu_addr),
      .in_agu_data(in_agu_data), .in_commit_tag(in_commit_tag), .out_full(out_full),
      .out_result(out_result), .out_rob_tag(out_rob_tag), .out_mem_ena(out_mem_ena),
      .out_mem_iswrite(out_mem_iswrite), .out_mem_addr(out_mem_addr),
      .out_mem_wdata(out_mem_wdata), .out_mem_size(out_mem_size),
      .in_mem_ready(in_mem_ready), .in_mem_rdata(in_mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic enq(input logic [ROB_W-1:0] tag, input logic st, input logic [2:0] f3);
      in_enq = 1'b1; in_enq_tag = tag; in_enq_store = st; in_enq_funct3 = f3;
      step();
      in_enq = 1'b0; in_enq_tag = '0; in_enq_store = 1'b0; in_enq_funct3 = '0;
   endtask

   task automatic agu(input logic [ROB_W-1:0] tag, input logic [31:0] addr, input logic [31:0] data);
      in_agu_tag = tag; in_agu_addr = addr; in_agu_data = data;
      step();
      in_agu_tag = '0; in_agu_addr = '0; in_agu_data = '0;
   endtask

   task automatic commit(input logic [ROB_W-1:0] tag);
      in_commit_tag = tag;
      step();
      in_commit_tag = '0;
   endtask

   task automatic mem_ready(input logic [31:0] data);
      in_mem_ready = 1'b1; in_mem_rdata = data;
      step();
      in_mem_ready = 1'b0; in_mem_rdata = '0;
   endtask

   initial begin
      rst_n = 1'b0; in_rollback = 1'b0; in_enq = 1'b0; in_enq_tag = '0; in_enq_store = 1'b0;
      in_enq_funct3 = '0; in_agu_tag = '0; in_agu_addr = '0; in_agu_data = '0;
      in_commit_tag = '0; in_mem_ready = 1'b0; in_mem_rdata = '0;
      step(); step();
      chk("rst_full", 32'(out_full), 0);
      chk("rst_ena", 32'(out_mem_ena), 0);
      chk("rst_tag", 32'(out_rob_tag), 0);
      chk("rst_result", out_result, 0);
      rst_n = 1'b1;
      step();

      // LB tag 3 @0x100, memory returns 0x80
      enq(4'd3, 1'b0, 3'b000);
      agu(4'd3, 32'h100, 32'h0);
      chk("lb_ena", 32'(out_mem_ena), 1);
      chk("lb_iswrite", 32'(out_mem_iswrite), 0);
      chk("lb_addr", out_mem_addr, 32'h100);
      chk("lb_size", 32'(out_mem_size), 1);
      step();
      chk("lb_pulse", 32'(out_mem_ena), 0);
      mem_ready(32'h80);
      chk("lb_tag", 32'(out_rob_tag), 3);
      chk("lb_result", out_result, 32'hFFFF_FF80);
      step();
      chk("lb_tag_clear", 32'(out_rob_tag), 0);

      // LBU tag 4
      enq(4'd4, 1'b0, 3'b100);
      agu(4'd4, 32'h104, 32'h0);
      chk("lbu_ena", 32'(out_mem_ena), 1);
      mem_ready(32'h80);
      chk("lbu_tag", 32'(out_rob_tag), 4);
      chk("lbu_result", out_result, 32'h0000_0080);

      // SW tag 2 waits for commit
      enq(4'd2, 1'b1, 3'b010);
      agu(4'd2, 32'h10, 32'h55);
      chk("sw_nocommit0", 32'(out_mem_ena), 0);
      step();
      chk("sw_nocommit1", 32'(out_mem_ena), 0);
      commit(4'd2);
      chk("sw_ena", 32'(out_mem_ena), 1);
      chk("sw_iswrite", 32'(out_mem_iswrite), 1);
      chk("sw_size", 32'(out_mem_size), 4);
      chk("sw_wdata", out_mem_wdata, 32'h55);
      chk("sw_addr", out_mem_addr, 32'h10);
      mem_ready(32'h0);
      chk("sw_no_result", 32'(out_rob_tag), 0);

      // Fill across the wrap point, drop an extra enqueue, then drain
      chk("fill_empty_full", 32'(out_full), 0);
      for (int t = 5; t <= 8; t++) enq(4'(t), 1'b0, 3'b010);
      chk("fill_full", 32'(out_full), 1);
      enq(4'd9, 1'b0, 3'b010);
      chk("fill_full_drop", 32'(out_full), 1);
      agu(4'd5, 32'h200, 32'h0);
      chk("fill_issue_ena", 32'(out_mem_ena), 1);
      chk("fill_issue_addr", out_mem_addr, 32'h200);
      chk("fill_after_issue", 32'(out_full), 0);
      mem_ready(32'h1234);
      chk("fill_tag5", 32'(out_rob_tag), 5);
      chk("fill_res5", out_result, 32'h1234);
      for (int t = 6; t <= 8; t++) begin
         agu(4'(t), 32'h200 + 32'(4 * (t - 5)), 32'h0);
         chk("drain_ena", 32'(out_mem_ena), 1);
         chk("drain_addr", out_mem_addr, 32'h200 + 32'(4 * (t - 5)));
         mem_ready(32'h1000 + 32'(t));
         chk("drain_tag", 32'(out_rob_tag), 32'(t));
         chk("drain_res", out_result, 32'h1000 + 32'(t));
      end
      agu(4'd9, 32'h300, 32'h0);
      chk("dropped_enq_absent", 32'(out_mem_ena), 0);

      // Rollback while load 2 is outstanding; committed store 1 survives, load 3 is flushed
      enq(4'd2, 1'b0, 3'b010);
      enq(4'd1, 1'b1, 3'b010);
      enq(4'd3, 1'b0, 3'b010);
      agu(4'd1, 32'h30, 32'h77);
      commit(4'd1);
      agu(4'd3, 32'h40, 32'h0);
      chk("rb_blocked", 32'(out_mem_ena), 0);
      agu(4'd2, 32'h50, 32'h0);
      chk("rb_ld_ena", 32'(out_mem_ena), 1);
      chk("rb_ld_addr", out_mem_addr, 32'h50);
      in_rollback = 1'b1;
      step();
      in_rollback = 1'b0;
      chk("rb_no_result", 32'(out_rob_tag), 0);
      mem_ready(32'h99);
      chk("rb_late_ready", 32'(out_rob_tag), 0);
      chk("rb_st_ena", 32'(out_mem_ena), 1);
      chk("rb_st_iswrite", 32'(out_mem_iswrite), 1);
      chk("rb_st_addr", out_mem_addr, 32'h30);
      chk("rb_st_wdata", out_mem_wdata, 32'h77);
      mem_ready(32'h0);
      agu(4'd3, 32'h40, 32'h0);
      chk("rb_ld3_flushed", 32'(out_mem_ena), 0);

      // Async reset with a load in flight
      enq(4'd4, 1'b0, 3'b010);
      agu(4'd4, 32'h60, 32'h0);
      chk("ar_ena_before", 32'(out_mem_ena), 1);
      rst_n = 1'b0;
      #1;
      chk("ar_ena", 32'(out_mem_ena), 0);
      chk("ar_addr", out_mem_addr, 0);
      chk("ar_size", 32'(out_mem_size), 0);
      chk("ar_tag", 32'(out_rob_tag), 0);
      chk("ar_full", 32'(out_full), 0);
      step();
      rst_n = 1'b1;
      mem_ready(32'hDEAD);
      chk("ar_no_result", 32'(out_rob_tag), 0);
      chk("ar_no_ena", 32'(out_mem_ena), 0);

      // SW 0x12345678 @0x40 uncommitted, then LH @0x40
      enq(4'd5, 1'b1, 3'b010);
      enq(4'd6, 1'b0, 3'b001);
      agu(4'd5, 32'h40, 32'h1234_5678);
      agu(4'd6, 32'h40, 32'h0);
      chk("fw_no_issue", 32'(out_mem_ena), 0);
      step();
`ifdef LSQ_FORWARD_EN
      chk("fw_tag", 32'(out_rob_tag), 6);
      chk("fw_result", out_result, 32'h0000_5678);
`else
      chk("nofw_tag", 32'(out_rob_tag), 0);
`endif
      chk("fw_no_mem", 32'(out_mem_ena), 0);
      commit(4'd5);
      chk("fw_st_ena", 32'(out_mem_ena), 1);
      chk("fw_st_wdata", out_mem_wdata, 32'h1234_5678);
      mem_ready(32'h0);
      step();
`ifdef LSQ_FORWARD_EN
      chk("fw_deq_no_mem", 32'(out_mem_ena), 0);
      chk("fw_no_dup", 32'(out_rob_tag), 0);
`else
      chk("nofw_ld_ena", 32'(out_mem_ena), 1);
      chk("nofw_ld_addr", out_mem_addr, 32'h40);
      chk("nofw_ld_size", 32'(out_mem_size), 2);
      mem_ready(32'h0000_8001);
      chk("nofw_tag", 32'(out_rob_tag), 6);
      chk("nofw_result", out_result, 32'hFFFF_8001);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lsq_param.md
# lsq_param

Parametrised load/store queue between dispatch, the ROB and the single-port memory controller. Holds memory ops in program order, captures address/data from the address-generation broadcast, issues loads speculatively and stores only after ROB commit, and broadcasts load results (sign- or zero-extended) to ROB/RS. It generalises the earlier fixed-depth queue:
- configurable depth and widths
- unsigned loads (LBU/LHU)
- a full flag
- optional store-to-load forwarding

## Interface
- DEPTH, 16, entry count, power of two ≥ 2
- ROB_W, 4, ROB tag width; tag 0 = "no tag"
- DATA_W, 32, data and address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_rollback  in  1  mispredict flush
- in_enq  in  1  enqueue strobe (ignored when out_full)
- in_enq_tag  in  ROB_W  ROB tag of enqueued op
- in_enq_store  in  1  1 = store, 0 = load
- in_enq_funct3  in  3  RISC-V funct3
- in_agu_tag  in  ROB_W  address/data broadcast tag (0 = none)
- in_agu_addr  in  DATA_W  effective address
- in_agu_data  in  DATA_W  store data
- in_commit_tag  in  ROB_W  ROB commit tag (0 = none)
- out_full  out  1  count == DEPTH
- out_result  out  DATA_W  load result
- out_rob_tag  out  ROB_W  result tag, 0 = no result this cycle
- out_mem_ena  out  1  one-cycle request pulse
- out_mem_iswrite  out  1  request is a store
- out_mem_addr  out  DATA_W  request address
- out_mem_wdata  out  DATA_W  store data
- out_mem_size  out  3  1/2/4 bytes
- in_mem_ready  in  1  request complete (one-cycle pulse)
- in_mem_rdata  in  DATA_W  read data, valid with in_mem_ready

## Operation
- Circular buffer with head, tail and a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Per-entry state: tag, store, funct3, addr, data, valid (AGU seen), committed, done (forwarded).
- Enqueue: writes at tail, clears valid/committed/done. An enqueue while full is dropped.
- AGU broadcast: every entry whose tag matches sets addr, data and valid. Commit broadcast: a matching entry sets committed.
- FSM states: IDLE, WAIT_ST, WAIT_LD.
- IDLE, head entry done: dequeue it with no memory access.
- IDLE, head is a valid load, or a valid and committed store:
  - pulse out_mem_ena, drive the request, dequeue the head.
  - go to WAIT_LD or WAIT_ST; latch tag and funct3.
- WAIT_*: on in_mem_ready return to IDLE. From WAIT_LD, also drive out_rob_tag and out_result.
- Size mapping: funct3[1:0] 00→1, 01→2, else→4.
- Extension: funct3 000 → sign-extend byte, 001 → sign-extend half, 100 → zero-extend byte, 101 → zero-extend half, else raw data.
- Rollback: every uncommitted entry is removed.
  - tail = slot after the youngest committed store; count is adjusted to match. If no committed store remains, queue empties (head = tail = 0).
  - WAIT_LD: go to IDLE and suppress the pending result (a late in_mem_ready is ignored).
  - WAIT_ST: keep waiting; the store completes.
  - Rollback has priority over enqueue, broadcasts and issue in the same cycle.
- Simultaneous enqueue and dequeue: count unchanged. A dequeue frees a slot only in the next cycle; out_full is computed from the registered count.

## Timing
- Reset (async): head = tail = count = 0, state IDLE, all valid/committed/done cleared. All outputs 0, out_full 0.
- out_mem_ena, out_rob_tag and out_result are registered and default to 0 each cycle. Results are valid only in the cycle out_rob_tag ≠ 0.
- AGU or commit at cycle N → earliest issue at N+1.
- Memory result appears on outputs the cycle after in_mem_ready.
- At most one memory op outstanding; at most one dequeue per cycle.
- Forwarded result: 1 cycle after the conditions hold. A memory result in the same cycle takes priority; the forward retries the next cycle.

## Configuration
- LSQ_FORWARD_EN defined: a non-head load may complete by forwarding when all of the following hold:
  - it is valid and not done;
  - every older entry is a valid store;
  - the youngest older store has an exact address match and its size ≥ the load size.
- The forwarded data is that store's data, extended per the load's funct3. The load then sets done and is dequeued when it reaches the head.
- With at most one forward per cycle, the oldest eligible load wins.
- Undefined: no forwarding logic; done is never set.

## Test plan
- Reset mid-WAIT_LD: deassert rst_n → all outputs 0 immediately; no result after release even if in_mem_ready arrives.
- LB at tag 3, addr 0x100, mem returns 0x80 → out_rob_tag = 3, out_result = 0xFFFFFF80. Same with LBU → 0x00000080.
- Store tag 2 (SW 0x55 @0x10) enqueued, AGU seen, no commit → no out_mem_ena. Commit tag 2 → next-cycle write pulse, size 4, wdata 0x55.
- Fill DEPTH entries → out_full = 1; extra enqueue ignored. Issue one at the wrap boundary → out_full = 0, tail wraps to 0.
- Committed store tag 1, uncommitted loads tags 2 and 3, rollback during WAIT_LD for tag 2 → no result for 2; tag 3 flushed; store 1 still issues.
- LSQ_FORWARD_EN: SW 0x12345678 @0x40 (uncommitted), LH @0x40 valid → result 0x00005678 with no memory read. Undefined build → load waits for memory.
